// File: rtl/bin_lut_loader_pkg.sv
// Shared definitions for the binarisation LUT loader: FSM states, channel
// indices and the per-bit pass/block word patterns.
package bin_lut_loader_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitVs = 2'd1,
        StWrite  = 2'd2
    } state_e;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_R   = 2;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_B   = 0;

    // Replicated to DATA_W at the point of use.
    localparam logic LUT_PASS  = 1'b1;
    localparam logic LUT_BLOCK = 1'b0;

endpackage

// File: rtl/bin_lut_entry_gen.sv
// Per-channel threshold comparator and LUT write-data former.
// Output is forced to zero when the channel is not being written.
module bin_lut_entry_gen
    import bin_lut_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_thr,
    input  logic              i_invert,
    output logic [DATA_W-1:0] o_data
);

    logic w_pass;

    assign w_pass = (i_addr >= i_thr) ^ i_invert;

    always_comb begin
        o_data = '0;
        if (i_en) begin
            o_data = w_pass ? {DATA_W{LUT_PASS}} : {DATA_W{LUT_BLOCK}};
        end
    end

endmodule

// File: rtl/bin_lut_loader.sv
// Rewrites the R/G/B binarisation LUTs inside the vertical sync pulse and
// muxes each LUT address port between the live pixel path and the loader.
module bin_lut_loader
    import bin_lut_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter logic        VS_ACTIVE = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [2:0]        i_cfg_mask,
    input  logic              i_cfg_invert,
    input  logic [ADDR_W-1:0] i_cfg_thr_r,
    input  logic [ADDR_W-1:0] i_cfg_thr_g,
    input  logic [ADDR_W-1:0] i_cfg_thr_b,
    input  logic              i_v_sync,
    input  logic [ADDR_W-1:0] i_pix_r,
    input  logic [ADDR_W-1:0] i_pix_g,
    input  logic [ADDR_W-1:0] i_pix_b,
    output logic [ADDR_W-1:0] o_lut_addr_r,
    output logic [ADDR_W-1:0] o_lut_addr_g,
    output logic [ADDR_W-1:0] o_lut_addr_b,
    output logic [DATA_W-1:0] o_lut_data_r,
    output logic [DATA_W-1:0] o_lut_data_g,
    output logic [DATA_W-1:0] o_lut_data_b,
    output logic [2:0]        o_lut_wren,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [2:0]        r_mask;
    logic              r_invert;
    logic [ADDR_W-1:0] r_thr_r;
    logic [ADDR_W-1:0] r_thr_g;
    logic [ADDR_W-1:0] r_thr_b;
    logic              r_vs_q;
    logic              r_cfg_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;

    logic              w_sync_start;
    logic [2:0]        w_wren;

    // vs_q tracks the line every cycle so a load accepted mid-pulse sees no edge.
    assign w_sync_start = (i_v_sync == VS_ACTIVE) && (r_vs_q != VS_ACTIVE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_invert    <= 1'b0;
            r_thr_r     <= '0;
            r_thr_g     <= '0;
            r_thr_b     <= '0;
            r_vs_q      <= ~VS_ACTIVE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_vs_q <= i_v_sync;
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cfg_valid && r_cfg_ready) begin
                        r_mask    <= i_cfg_mask;
                        r_invert  <= i_cfg_invert;
                        r_thr_r   <= i_cfg_thr_r;
                        r_thr_g   <= i_cfg_thr_g;
                        r_thr_b   <= i_cfg_thr_b;
                        r_overrun <= 1'b0;
                        if (i_cfg_mask == 3'b000) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= StWaitVs;
                            r_cfg_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                StWaitVs: begin
                    if (w_sync_start) begin
                        r_cnt   <= '0;
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    if (i_v_sync != VS_ACTIVE) begin
                        r_overrun <= 1'b1;
                    end
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == CNT_MAX) begin
                        r_state     <= StIdle;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_wren = (r_state == StWrite) ? r_mask : 3'b000;

    assign o_lut_wren   = w_wren;
    assign o_lut_addr_r = w_wren[CH_R] ? r_cnt : i_pix_r;
    assign o_lut_addr_g = w_wren[CH_G] ? r_cnt : i_pix_g;
    assign o_lut_addr_b = w_wren[CH_B] ? r_cnt : i_pix_b;

    assign o_cfg_ready = r_cfg_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overrun   = r_overrun;

    bin_lut_entry_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_gen_r (
        .i_en     (w_wren[CH_R]),
        .i_addr   (r_cnt),
        .i_thr    (r_thr_r),
        .i_invert (r_invert),
        .o_data   (o_lut_data_r)
    );

    bin_lut_entry_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_gen_g (
        .i_en     (w_wren[CH_G]),
        .i_addr   (r_cnt),
        .i_thr    (r_thr_g),
        .i_invert (r_invert),
        .o_data   (o_lut_data_g)
    );

    bin_lut_entry_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_gen_b (
        .i_en     (w_wren[CH_B]),
        .i_addr   (r_cnt),
        .i_thr    (r_thr_b),
        .i_invert (r_invert),
        .o_data   (o_lut_data_b)
    );

endmodule

// File: tb/tb_bin_lut_loader.sv
// Scoreboard bench for bin_lut_loader: expected LUT writes are queued at
// config accept; a negedge monitor pops and compares every observed write.
module tb_bin_lut_loader;

    typedef struct {
        int         ch;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_mask;
    logic       cfg_invert;
    logic [7:0] thr_r, thr_g, thr_b;
    logic       v_sync;
    logic [7:0] pix_r, pix_g, pix_b;
    logic [7:0] addr_r, addr_g, addr_b;
    logic [7:0] data_r, data_g, data_b;
    logic [2:0] wren;
    logic       busy, done, overrun;

    logic [7:0] addr_a [3];
    logic [7:0] data_a [3];
    logic [7:0] pix_a  [3];
    logic [7:0] lut    [3][256];

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  wr_cycles = 0;
    int  done_cnt = 0;

    assign addr_a[2] = addr_r;
    assign addr_a[1] = addr_g;
    assign addr_a[0] = addr_b;
    assign data_a[2] = data_r;
    assign data_a[1] = data_g;
    assign data_a[0] = data_b;
    assign pix_a[2]  = pix_r;
    assign pix_a[1]  = pix_g;
    assign pix_a[0]  = pix_b;

    always #5 clk = ~clk;

    bin_lut_loader dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_mask   (cfg_mask),
        .i_cfg_invert (cfg_invert),
        .i_cfg_thr_r  (thr_r),
        .i_cfg_thr_g  (thr_g),
        .i_cfg_thr_b  (thr_b),
        .i_v_sync     (v_sync),
        .i_pix_r      (pix_r),
        .i_pix_g      (pix_g),
        .i_pix_b      (pix_b),
        .o_lut_addr_r (addr_r),
        .o_lut_addr_g (addr_g),
        .o_lut_addr_b (addr_b),
        .o_lut_data_r (data_r),
        .o_lut_data_g (data_g),
        .o_lut_data_b (data_b),
        .o_lut_wren   (wren),
        .o_busy       (busy),
        .o_done       (done),
        .o_overrun    (overrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] thr,
                                         input logic inv);
        return ((a >= thr) ^ inv) ? 8'hFF : 8'h00;
    endfunction

    task automatic push_load(input logic [2:0] m, input logic inv,
                             input logic [7:0] tr, input logic [7:0] tg, input logic [7:0] tb);
        logic [7:0] th [3];
        th[2] = tr;
        th[1] = tg;
        th[0] = tb;
        for (int a = 0; a < 256; a++) begin
            for (int c = 2; c >= 0; c--) begin
                if (m[c]) exp_q.push_back('{c, 8'(a), model(8'(a), th[c], inv)});
            end
        end
    endtask

    task automatic issue(input logic [2:0] m, input logic inv,
                         input logic [7:0] tr, input logic [7:0] tg, input logic [7:0] tb);
        int n;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_mask = m; cfg_invert = inv;
        thr_r = tr; thr_g = tg; thr_b = tb;
        n = 0;
        do begin @(negedge clk); n++; end while (!cfg_ready && n < 2000);
        if (!cfg_ready) chk("accept_timeout", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        push_load(m, inv, tr, tg, tb);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < budget);
        chk(nm, 32'(done), 32'd1);
    endtask

    // Live pixel stream, changes every cycle.
    initial begin
        pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
        forever begin
            @(posedge clk); #1;
            pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
        end
    end

    // Monitor: pops expected writes, checks pass-through on idle channels.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wren != 3'b000) wr_cycles++;
                if (done) done_cnt++;
                for (int c = 2; c >= 0; c--) begin
                    if (wren[c]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write", {24'd0, addr_a[c]}, 32'hFFFF_FFFF);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            chk("wr_addr", {24'd0, addr_a[c]}, {24'd0, e.addr});
                            chk("wr_data", {24'd0, data_a[c]}, {24'd0, e.data});
                        end
                        lut[c][addr_a[c]] = data_a[c];
                    end else begin
                        chk("passthru", {16'd0, addr_a[c], data_a[c]}, {16'd0, pix_a[c], 8'h00});
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int c = 0; c < 3; c++) for (int a = 0; a < 256; a++) lut[c][a] = 8'hXX;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mask = 3'b000; cfg_invert = 1'b0;
        thr_r = 8'h00; thr_g = 8'h00; thr_b = 8'h00; v_sync = 1'b1;

        // 1: reset values and pass-through
        #22;
        chk("t1_ready_rst", 32'(cfg_ready), 32'd1);
        chk("t1_wren_rst", 32'(wren), 32'd0);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t1_addr_r", {24'd0, addr_r}, {24'd0, pix_r});
            chk("t1_idle", {28'd0, cfg_ready, busy, done, overrun}, 32'b1000);
        end

        // 2: full load, write timing and spot values
        issue(3'b111, 1'b0, 8'h80, 8'h40, 8'hC0);
        chk("t2_busy", {30'd0, busy, cfg_ready}, 32'b10);
        wr_cycles = 0; done_cnt = 0;
        v_sync = 1'b0;
        @(negedge clk);
        chk("t2_no_early_write", 32'(wren), 32'd0);
        @(negedge clk);
        chk("t2_first_write", {21'd0, wren, addr_r}, {21'd0, 3'b111, 8'h00});
        wait_done(300, "t2_done");
        chk("t2_len", 32'(wr_cycles), 32'd256);
        @(posedge clk); #1 v_sync = 1'b1;
        repeat (4) @(negedge clk);
        chk("t2_done_once", 32'(done_cnt), 32'd1);
        chk("t2_ready_after", {30'd0, cfg_ready, overrun}, 32'b10);
        chk("t2_r7f", {24'd0, lut[2][8'h7F]}, 32'h00);
        chk("t2_r80", {24'd0, lut[2][8'h80]}, 32'hFF);
        chk("t2_g3f", {24'd0, lut[1][8'h3F]}, 32'h00);
        chk("t2_g40", {24'd0, lut[1][8'h40]}, 32'hFF);
        chk("t2_bbf", {24'd0, lut[0][8'hBF]}, 32'h00);
        chk("t2_bc0", {24'd0, lut[0][8'hC0]}, 32'hFF);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: green only, inverted
        issue(3'b010, 1'b1, 8'h55, 8'h10, 8'h55);
        wr_cycles = 0;
        v_sync = 1'b0;
        wait_done(300, "t3_done");
        chk("t3_len", 32'(wr_cycles), 32'd256);
        @(posedge clk); #1 v_sync = 1'b1;
        chk("t3_g0f", {24'd0, lut[1][8'h0F]}, 32'hFF);
        chk("t3_g10", {24'd0, lut[1][8'h10]}, 32'h00);
        chk("t3_r_kept", {24'd0, lut[2][8'h80]}, 32'hFF);
        chk("t3_b_kept", {24'd0, lut[0][8'hC0]}, 32'hFF);

        // 4: request held during WRITE, accepted on done, waits for next pulse
        issue(3'b101, 1'b0, 8'h10, 8'h00, 8'hF0);
        v_sync = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_mask = 3'b011; cfg_invert = 1'b1;
        thr_r = 8'h00; thr_g = 8'h22; thr_b = 8'h33;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (!done) chk("t4_held", 32'(cfg_ready), 32'd0);
        end while (!done && n < 300);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_ready_on_done", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        push_load(3'b011, 1'b1, 8'h00, 8'h22, 8'h33);
        v_sync = 1'b1;
        chk("t4_lut_r0f", {24'd0, lut[2][8'h0F]}, 32'h00);
        chk("t4_lut_bf0", {24'd0, lut[0][8'hF0]}, 32'hFF);
        repeat (20) begin
            @(negedge clk);
            chk("t4_wait_pulse", {29'd0, wren}, {29'd0, 3'b000});
        end
        chk("t4_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 v_sync = 1'b0;
        wait_done(300, "t4_second_done");
        @(posedge clk); #1 v_sync = 1'b1;
        chk("t4_g21", {24'd0, lut[1][8'h21]}, 32'hFF);
        chk("t4_b33", {24'd0, lut[0][8'h33]}, 32'h00);
        chk("t4_no_ovr", 32'(overrun), 32'd0);

        // 5: short pulse -> overrun sticky, cleared on next accept
        issue(3'b111, 1'b0, 8'h01, 8'h02, 8'h03);
        wr_cycles = 0;
        v_sync = 1'b0;
        repeat (100) @(posedge clk);
        #1 v_sync = 1'b1;
        wait_done(300, "t5_done");
        chk("t5_len", 32'(wr_cycles), 32'd256);
        chk("t5_ovr", 32'(overrun), 32'd1);
        repeat (5) @(negedge clk);
        chk("t5_ovr_sticky", 32'(overrun), 32'd1);
        issue(3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("t5_mask0_done", {30'd0, done, overrun}, 32'b10);

        // 6: async reset mid-WRITE, then re-issue
        issue(3'b111, 1'b0, 8'h20, 8'hA0, 8'h70);
        v_sync = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(wren[2] && addr_r == 8'h55) && n < 300);
        chk("t6_reach_55", {24'd0, addr_r}, 32'h55);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_wren", 32'(wren), 32'd0);
        chk("t6_rst_flags", {28'd0, cfg_ready, busy, done, overrun}, 32'b1000);
        chk("t6_rst_addr", {24'd0, addr_r}, {24'd0, pix_r});
        v_sync = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(3'b111, 1'b0, 8'h20, 8'hA0, 8'h70);
        v_sync = 1'b0;
        wait_done(300, "t6_done");
        @(posedge clk); #1 v_sync = 1'b1;
        for (int a = 0; a < 256; a++) begin
            chk("t6_tbl_r", {24'd0, lut[2][a]}, {24'd0, model(8'(a), 8'h20, 1'b0)});
            chk("t6_tbl_g", {24'd0, lut[1][a]}, {24'd0, model(8'(a), 8'hA0, 1'b0)});
            chk("t6_tbl_b", {24'd0, lut[0][a]}, {24'd0, model(8'(a), 8'h70, 1'b0)});
        end
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
